// File: rtl/bcd_chrono_core.sv
// bcd_chrono_core: DIGITS-wide BCD stopwatch/timer counter with run-state FSM.
// Optional lap-hold display freeze: define CHRONO_LAP_HOLD_EN.
module bcd_chrono_core #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic                  tick,
    input  logic                  s,
    input  logic                  clr,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   preval,
`ifdef CHRONO_LAP_HOLD_EN
    input  logic                  lap,
    output logic                  lap_active,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  sat
);

    localparam int W = 4 * DIGITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [W-1:0] ALL9 = {DIGITS{4'h9}};

    logic [W-1:0] cnt_q, cnt_d;
    logic [1:0]   state_q, state_d;
    logic         dir_q, dir_d;
    logic         load_pend_q, load_pend_d;
    logic         done_q, done_d;
    logic         running_q, sat_q;
    logic         s_q, clr_q;

    logic         s_e, clr_e, load;
    logic [W-1:0] up_v, dn_v, step_v, ld_v, term_v;
    logic         up_c, dn_b;

    assign s_e    = s & ~s_q;
    assign clr_e  = clr & ~clr_q;
    assign load   = clr_e | load_pend_q;
    assign term_v = dir_q ? '0 : ALL9;
    assign step_v = dir_q ? dn_v : up_v;

    // BCD increment/decrement of the live count, plus the clamped load value
    always_comb begin
        up_v = cnt_q;
        dn_v = cnt_q;
        ld_v = '0;
        up_c = 1'b1;
        dn_b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (up_c) begin
                if (cnt_q[4*i +: 4] >= 4'd9) begin
                    up_v[4*i +: 4] = 4'd0;
                end else begin
                    up_v[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    up_c = 1'b0;
                end
            end
            if (dn_b) begin
                if (cnt_q[4*i +: 4] == 4'd0) begin
                    dn_v[4*i +: 4] = 4'd9;
                end else begin
                    dn_v[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                    dn_b = 1'b0;
                end
            end
            unique case (mode)
                2'b00:   ld_v[4*i +: 4] = 4'd0;
                2'b10:   ld_v[4*i +: 4] = 4'd9;
                default: ld_v[4*i +: 4] = (preval[4*i +: 4] > 4'd9) ?
                                          4'd9 : preval[4*i +: 4];
            endcase
        end
    end

    // Next-state: load first, then FSM transitions and tick-driven counting
    always_comb begin
        cnt_d       = cnt_q;
        state_d     = state_q;
        dir_d       = dir_q;
        load_pend_d = load_pend_q;
        done_d      = 1'b0;
        if (load) begin
            cnt_d       = ld_v;
            state_d     = IDLE;
            dir_d       = mode[1];
            load_pend_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (s_e) state_d = RUN;
                end
                RUN: begin
                    if (tick) begin
                        if (cnt_q == term_v) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = step_v;
                            if (step_v == term_v) begin
                                state_d = DONE;
                                done_d  = 1'b1;
                            end
                        end
                    end
                    if (s_e && state_d != DONE) state_d = PAUSE;
                end
                PAUSE: begin
                    if (s_e) state_d = RUN;
                end
                default: ;
            endcase
        end
    end

    // Registered counter, FSM, button history and status flags
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt_q       <= '0;
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            load_pend_q <= 1'b1;
            done_q      <= 1'b0;
            running_q   <= 1'b0;
            sat_q       <= 1'b0;
            s_q         <= 1'b1;
            clr_q       <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            dir_q       <= dir_d;
            load_pend_q <= load_pend_d;
            done_q      <= done_d;
            running_q   <= (state_d == RUN);
            sat_q       <= (state_d == DONE);
            s_q         <= s;
            clr_q       <= clr;
        end
    end

    assign running = running_q;
    assign done    = done_q;
    assign sat     = sat_q;

`ifdef CHRONO_LAP_HOLD_EN
    logic         lap_q, lap_e;
    logic         lap_act_q, lap_act_d;
    logic [W-1:0] frz_q, frz_d;

    assign lap_e = lap & ~lap_q;

    // Lap toggle: freeze the displayed value on entry, release on exit
    always_comb begin
        lap_act_d = lap_act_q;
        frz_d     = frz_q;
        if (load) begin
            lap_act_d = 1'b0;
        end else if (lap_e) begin
            lap_act_d = ~lap_act_q;
            if (!lap_act_q) frz_d = cnt_q;
        end
    end

    // Lap-hold registers
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            lap_q     <= 1'b1;
            lap_act_q <= 1'b0;
            frz_q     <= '0;
        end else begin
            lap_q     <= lap;
            lap_act_q <= lap_act_d;
            frz_q     <= frz_d;
        end
    end

    assign lap_active = lap_act_q;
    assign count      = lap_act_q ? frz_q : cnt_q;
`else
    assign count = cnt_q;
`endif

endmodule

// File: tb/tb_bcd_chrono_core.sv
// tb_bcd_chrono_core: directed checks of bcd_chrono_core (DIGITS=4).
// Covers lap-hold too when CHRONO_LAP_HOLD_EN is defined.
module tb_bcd_chrono_core;

    logic        clk = 1'b0;
    logic        r = 1'b0;
    logic        tick = 1'b0;
    logic        s = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] preval = '0;
    logic [15:0] count;
    logic        running, done, sat;
`ifdef CHRONO_LAP_HOLD_EN
    logic        lap = 1'b0;
    logic        lap_active;
`endif

    int ntests = 0;
    int nfail = 0;
    int done_seen = 0;

    bcd_chrono_core #(.DIGITS(4)) dut (
        .clk(clk),
        .r(r),
        .tick(tick),
        .s(s),
        .clr(clr),
        .mode(mode),
        .preval(preval),
`ifdef CHRONO_LAP_HOLD_EN
        .lap(lap),
        .lap_active(lap_active),
`endif
        .count(count),
        .running(running),
        .done(done),
        .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] preval;
        logic [15:0] exp_load;
        logic [15:0] exp_tick;
        logic        exp_done;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        done_seen += int'(done);
    endtask

    task automatic do_reset(input logic [1:0] m);
        mode = m;
        r = 1'b1;
        #1;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_flags", {29'd0, running, done, sat}, 32'h0);
        step();
        r = 1'b0;
        step();
    endtask

    task automatic pulse_s();
        s = 1'b1;
        step();
        s = 1'b0;
        step();
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            step();
        end
    endtask

    initial begin
        vecs[0] = '{2'b00, 16'h1234, 16'h0000, 16'h0001, 1'b0};
        vecs[1] = '{2'b10, 16'h1234, 16'h9999, 16'h9998, 1'b0};
        vecs[2] = '{2'b01, 16'h0199, 16'h0199, 16'h0200, 1'b0};
        vecs[3] = '{2'b11, 16'h1000, 16'h1000, 16'h0999, 1'b0};
        vecs[4] = '{2'b01, 16'h0009, 16'h0009, 16'h0010, 1'b0};
        vecs[5] = '{2'b11, 16'h0001, 16'h0001, 16'h0000, 1'b1};
        vecs[6] = '{2'b01, 16'h9998, 16'h9998, 16'h9999, 1'b1};
        vecs[7] = '{2'b11, 16'h00A0, 16'h0090, 16'h0089, 1'b0};
        vecs[8] = '{2'b01, 16'hFFFF, 16'h9999, 16'h9999, 1'b1};
        vecs[9] = '{2'b11, 16'hA0B1, 16'h9091, 16'h9090, 1'b0};

        // up from zero, then pause
        do_reset(2'b00);
        chk("idle_count", 32'(count), 32'h0);
        pulse_s();
        chk("start_run", 32'(running), 32'h1);
        ticks(12);
        chk("up12", 32'(count), 32'h0012);
        chk("up12_run", 32'(running), 32'h1);
        pulse_s();
        ticks(5);
        chk("paused", 32'(count), 32'h0012);
        chk("paused_run", 32'(running), 32'h0);

        // down from clamped preset to zero
        mode = 2'b11;
        preval = 16'h3AF5;
        pulse_clr();
        chk("clamp_load", 32'(count), 32'h3995);
        pulse_s();
        ticks(1);
        chk("down1", 32'(count), 32'h3994);
        done_seen = 0;
        ticks(3994);
        chk("down_zero", 32'(count), 32'h0000);
        chk("done_once", 32'(done_seen), 32'd1);
        chk("sat_set", {30'd0, sat, running}, 32'h2);
        ticks(3);
        pulse_s();
        ticks(2);
        chk("hold_zero", 32'(count), 32'h0000);
        chk("hold_sat", 32'(sat), 32'h1);
        chk("no_redone", 32'(done_seen), 32'd1);

        // table: load value, one tick step, done pulse
        for (int k = 0; k < 10; k++) begin
            mode = vecs[k].mode;
            preval = vecs[k].preval;
            pulse_clr();
            chk($sformatf("v%0d_load", k), 32'(count),
                32'(vecs[k].exp_load));
            chk($sformatf("v%0d_sat0", k), 32'(sat), 32'h0);
            pulse_s();
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("v%0d_tick", k), 32'(count),
                32'(vecs[k].exp_tick));
            chk($sformatf("v%0d_done", k), 32'(done),
                32'(vecs[k].exp_done));
            step();
            chk($sformatf("v%0d_pulse", k), 32'(done), 32'h0);
            chk($sformatf("v%0d_sat", k), 32'(sat),
                32'(vecs[k].exp_done));
        end

        // up to all-nines, then stays saturated
        mode = 2'b01;
        preval = 16'h9998;
        pulse_clr();
        pulse_s();
        done_seen = 0;
        ticks(1);
        chk("top_9999", 32'(count), 32'h9999);
        ticks(1);
        chk("top_hold", 32'(count), 32'h9999);
        chk("top_done1", 32'(done_seen), 32'd1);

        // implicit load after reset, down with borrow
        do_reset(2'b10);
        chk("impl_load", 32'(count), 32'h9999);
        chk("impl_run", 32'(running), 32'h0);
        pulse_s();
        ticks(3);
        chk("dn3", 32'(count), 32'h9996);
        ticks(6);
        chk("dn9990", 32'(count), 32'h9990);
        ticks(1);
        chk("borrow", 32'(count), 32'h9989);

        // load beats simultaneous start/stop and tick
        mode = 2'b00;
        clr = 1'b1;
        s = 1'b1;
        tick = 1'b1;
        step();
        clr = 1'b0;
        s = 1'b0;
        tick = 1'b0;
        chk("ld_pri_cnt", 32'(count), 32'h0000);
        chk("ld_pri_run", {30'd0, running, sat}, 32'h0);
        ticks(2);
        chk("ld_pri_idle", 32'(count), 32'h0000);
        pulse_s();
        ticks(1);
        chk("ld_pri_up", 32'(count), 32'h0001);

`ifdef CHRONO_LAP_HOLD_EN
        pulse_clr();
        pulse_s();
        ticks(40);
        chk("lap_pre", 32'(count), 32'h0040);
        lap = 1'b1;
        step();
        lap = 1'b0;
        step();
        chk("lap_on", 32'(lap_active), 32'h1);
        ticks(10);
        chk("lap_frz", 32'(count), 32'h0040);
        lap = 1'b1;
        step();
        lap = 1'b0;
        step();
        chk("lap_off", 32'(lap_active), 32'h0);
        chk("lap_live", 32'(count), 32'h0050);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/bcd_chrono_core.md
Name: bcd_chrono_core

Overview:
- Parametrised stopwatch/timer counting engine for the seven-segment stopwatch: a DIGITS-wide BCD counter with four up/down/preset modes.
- Adds start/stop edge detection, a registered run-state FSM, a terminal-count done pulse and saturation flag.
- Sits between the tick divider (supplies `tick`) and the display scanner (consumes `count`).

Parameters:
- DIGITS, 4, number of BCD digits (≥1); digit 0 is least significant.

Ports:
- clk  in  1  system clock
- r  in  1  reset, asynchronous, active-high
- tick  in  1  count-enable strobe, one clk wide, from the tick divider
- s  in  1  start/stop button level, already debounced; rising edge acts
- clr  in  1  reload button level, already debounced; rising edge acts
- mode  in  2  00 up from zero, 01 up from preset, 10 down from all-nines, 11 down from preset
- preval  in  4*DIGITS  preset, one BCD nibble per digit
- count  out  4*DIGITS  current BCD value
- running  out  1  high while the FSM is in RUN
- done  out  1  one-cycle pulse when terminal count is reached
- sat  out  1  high while the FSM is in DONE

Behaviour:
- Reset (r=1, asynchronous):
  - count=0, state=IDLE, running=0, done=0, sat=0, dir=up.
  - s_q=1 and clr_q=1, so a button held through reset does not produce an edge.
  - load_pend=1.
- Edge detect: s_e = s & ~s_q; clr_e = clr & ~clr_q. s_q and clr_q register s and clr every clk.
- Load: occurs on clr_e, or on the first clk edge with load_pend=1 (which then clears load_pend).
  - mode and direction are latched at load: dir = mode[1]. Mode changes outside a load are ignored.
  - Load value by mode: 00 → all 0; 10 → all 9; 01/11 → preval, with any nibble greater than 9 clamped to 9 per digit.
  - Load forces state=IDLE and sat=0.
- Priority: load over everything else. A simultaneous s_e is discarded and any tick in that cycle is ignored.
- FSM, registered transitions:
  - IDLE: s_e → RUN.
  - RUN: s_e → PAUSE; terminal reached → DONE.
  - PAUSE: s_e → RUN.
  - DONE: s_e ignored; ticks ignored; leaves only via load.
- Counting is evaluated from the current (registered) state. The count updates on the clk edge where tick=1 and state=RUN, so count is visible 1 cycle after the tick.
  - tick coincident with a stop s_e in RUN: still counts, and the state goes to PAUSE.
  - tick coincident with a start s_e in IDLE/PAUSE: does not count.
- Terminal value: all 9s when dir=up; all 0s when dir=down.
- Tick in RUN when count already equals terminal: count unchanged → DONE, done pulse.
- Tick in RUN when count does not equal terminal:
  - Step count by ±1 in BCD.
  - Up: a digit at 9 wraps to 0 and carries into the next digit.
  - Down: a digit at 0 wraps to 9 and borrows from the next digit.
  - If the stepped value equals terminal: same edge → DONE, done=1 for one cycle.
- Saturation: count never wraps past terminal; it holds all-9s or all-0s until load.
- sat = (state==DONE); running = (state==RUN). Both are registered.
- done is a registered one-cycle pulse, asserted exactly once per DONE entry.
- Every count nibble is always 0..9. Out-of-range preval never reaches count.

Optional Feature:
- Macro: CHRONO_LAP_HOLD_EN.
- Defined:
  - Adds input `lap` (1 bit, debounced level, rising-edge detected, lap_q reset 1).
  - Adds output `lap_active` (1 bit).
  - A lap edge toggles lap_active; while lap_active=1, `count` shows a register frozen at the toggle edge.
  - The internal counter and FSM continue normally.
  - Load clears lap_active. Reset clears lap_active and the frozen register.
- Undefined: no lap port or logic; `count` always shows the live counter.

Test Plan (DIGITS=4):
- Reset, mode=00, s pulse, 12 ticks → count=0x0012, running=1. Second s pulse, 5 ticks → count stays 0x0012, running=0.
- mode=11, preval=0x3AF5, clr pulse → count=0x3995. s pulse, 1 tick → 0x3994. Continue to 0x0000 → done pulses once, sat=1. Further ticks and s edges → no change.
- mode=01, preval=0x9998, clr, s, 1 tick → 0x9999 with done pulse on the same update. Next tick → still 0x9999.
- mode=10 after reset, no clr: implicit load → 0x9999. s, 3 ticks → 0x9996. Ticks at 0x9990 → 0x9989 (borrow check).
- In RUN, clr and s rising in the same cycle as a tick → count = reload value, state IDLE, no count step.
- CHRONO_LAP_HOLD_EN: running up at 0x0040, lap edge → count frozen at 0x0040 during 10 ticks. Second lap edge → count=0x0050.
